fft_peak_analyzer: RTL and testbench

- Downstream analysis stage of the FAS datapath.
- Consumes each 16-bin FFT frame (fft_valid plus fft_d0..fft_d15, each {real[15:0], imag[15:0]}, signed 8.8).
- Computes per-bin magnitude squared serially, one bin per cycle, and reports the dominant bin index on freq with a one-cycle done pulse.
- Sustains back-to-back frames every 16 cycles using a one-frame holding buffer.

---
 rtl/fft_peak_analyzer.sv | 141 ++++++++++++++
 tb/tb_fft_peak_analyzer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_peak_analyzer.sv
// Serial peak finder for 16-bin FFT frames: one bin's magnitude squared per cycle,
// reporting the dominant bin; a one-frame holding bank absorbs back-to-back input.
module fft_peak_analyzer #(
  parameter bit SKIP_DC = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fft_valid,
  input  logic [31:0] fft_d0,
  input  logic [31:0] fft_d1,
  input  logic [31:0] fft_d2,
  input  logic [31:0] fft_d3,
  input  logic [31:0] fft_d4,
  input  logic [31:0] fft_d5,
  input  logic [31:0] fft_d6,
  input  logic [31:0] fft_d7,
  input  logic [31:0] fft_d8,
  input  logic [31:0] fft_d9,
  input  logic [31:0] fft_d10,
  input  logic [31:0] fft_d11,
  input  logic [31:0] fft_d12,
  input  logic [31:0] fft_d13,
  input  logic [31:0] fft_d14,
  input  logic [31:0] fft_d15,
  output logic        done,
  output logic [3:0]  freq,
  output logic [31:0] peak_mag,
  output logic        busy,
  output logic        ovf
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CALC = 1'b1;

  logic [0:0]  state_reg;
  logic [3:0]  idx_reg;
  logic [3:0]  maxidx_reg;
  logic [31:0] max_reg;
  logic        pend_reg;
  logic [31:0] work_reg [16];
  logic [31:0] hold_reg [16];
  logic [31:0] din [16];

  assign din[0]  = fft_d0;
  assign din[1]  = fft_d1;
  assign din[2]  = fft_d2;
  assign din[3]  = fft_d3;
  assign din[4]  = fft_d4;
  assign din[5]  = fft_d5;
  assign din[6]  = fft_d6;
  assign din[7]  = fft_d7;
  assign din[8]  = fft_d8;
  assign din[9]  = fft_d9;
  assign din[10] = fft_d10;
  assign din[11] = fft_d11;
  assign din[12] = fft_d12;
  assign din[13] = fft_d13;
  assign din[14] = fft_d14;
  assign din[15] = fft_d15;

  logic [31:0]        cur_bin;
  logic signed [15:0] re;
  logic signed [15:0] im;
  logic signed [31:0] re_sq;
  logic signed [31:0] im_sq;
  logic [31:0]        mag_raw;
  logic [31:0]        mag;
  logic               gt;

  assign cur_bin = work_reg[idx_reg];
  assign re      = cur_bin[31:16];
  assign im      = cur_bin[15:0];
  assign re_sq   = re * re;
  assign im_sq   = im * im;
  // Each square is at most 2^30, so the unsigned sum never exceeds 2^31.
  assign mag_raw = $unsigned(re_sq) + $unsigned(im_sq);
  assign mag     = (SKIP_DC && idx_reg == 4'd0) ? 32'd0 : mag_raw;
  assign gt      = mag > max_reg;
  assign busy    = (state_reg == CALC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      idx_reg    <= 4'd0;
      maxidx_reg <= 4'd0;
      max_reg    <= 32'd0;
      pend_reg   <= 1'b0;
      work_reg   <= '{default: 32'd0};
      hold_reg   <= '{default: 32'd0};
      done       <= 1'b0;
      freq       <= 4'd0;
      peak_mag   <= 32'd0;
      ovf        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (fft_valid) begin
            work_reg  <= din;
            idx_reg   <= 4'd0;
            state_reg <= CALC;
          end
        end
        default: begin
          idx_reg <= idx_reg + 4'd1;
          if (idx_reg == 4'd0) begin
            max_reg    <= mag;
            maxidx_reg <= 4'd0;
          end else if (idx_reg != 4'd15 && gt) begin
            max_reg    <= mag;
            maxidx_reg <= idx_reg;
          end

          if (idx_reg == 4'd15) begin
            done     <= 1'b1;
            freq     <= gt ? 4'd15 : maxidx_reg;
            peak_mag <= gt ? mag : max_reg;
            // A pending frame always runs before a frame arriving this cycle.
            if (pend_reg) begin
              work_reg <= hold_reg;
              if (fft_valid) hold_reg <= din;
              else           pend_reg <= 1'b0;
            end else if (fft_valid) begin
              work_reg <= din;
            end else begin
              state_reg <= IDLE;
            end
          end else if (fft_valid) begin
            if (!pend_reg) begin
              hold_reg <= din;
              pend_reg <= 1'b1;
            end else begin
              ovf <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_peak_analyzer.sv
// Randomized bench for fft_peak_analyzer: frame-level scheduling model plus an
// argmax reference, run against SKIP_DC=0 and SKIP_DC=1 instances in parallel.
module tb_fft_peak_analyzer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        fft_valid = 1'b0;
  logic [31:0] din [16];

  logic        done0, done1, busy0, busy1, ovf0, ovf1;
  logic [3:0]  freq0, freq1;
  logic [31:0] peak0, peak1;

  fft_peak_analyzer #(.SKIP_DC(1'b0)) dut0 (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(din[0]), .fft_d1(din[1]), .fft_d2(din[2]), .fft_d3(din[3]),
    .fft_d4(din[4]), .fft_d5(din[5]), .fft_d6(din[6]), .fft_d7(din[7]),
    .fft_d8(din[8]), .fft_d9(din[9]), .fft_d10(din[10]), .fft_d11(din[11]),
    .fft_d12(din[12]), .fft_d13(din[13]), .fft_d14(din[14]), .fft_d15(din[15]),
    .done(done0), .freq(freq0), .peak_mag(peak0), .busy(busy0), .ovf(ovf0)
  );

  fft_peak_analyzer #(.SKIP_DC(1'b1)) dut1 (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(din[0]), .fft_d1(din[1]), .fft_d2(din[2]), .fft_d3(din[3]),
    .fft_d4(din[4]), .fft_d5(din[5]), .fft_d6(din[6]), .fft_d7(din[7]),
    .fft_d8(din[8]), .fft_d9(din[9]), .fft_d10(din[10]), .fft_d11(din[11]),
    .fft_d12(din[12]), .fft_d13(din[13]), .fft_d14(din[14]), .fft_d15(din[15]),
    .done(done1), .freq(freq1), .peak_mag(peak1), .busy(busy1), .ovf(ovf1)
  );

  typedef struct {
    int          c;
    int          f;
    logic [31:0] m;
  } ev_t;

  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;
  ev_t cap0[$];
  ev_t cap1[$];
  ev_t exp0[$];
  ev_t exp1[$];
  bit  exp_ovf;
  logic [31:0] frm [64][16];
  int  off [64];
  int  win_lo = 0, win_hi = 0, busy_gaps = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Edge k's effects are visible at the following negedge, where cyc == k.
  always @(negedge clk) begin
    if (done0 === 1'b1) cap0.push_back('{cyc, int'(freq0), peak0});
    if (done1 === 1'b1) cap1.push_back('{cyc, int'(freq1), peak1});
    if (cyc >= win_lo && cyc < win_hi && busy0 !== 1'b1) busy_gaps++;
  end

  function automatic void ref_peak(input int id, input bit skip, output int f, output logic [31:0] m);
    longint best = -1;
    f = 0;
    for (int k = 0; k < 16; k++) begin
      shortint re = shortint'(frm[id][k][31:16]);
      shortint im = shortint'(frm[id][k][15:0]);
      longint  mm = (skip && k == 0) ? 64'sd0 : longint'(re) * longint'(re) + longint'(im) * longint'(im);
      if (mm > best) begin
        best = mm;
        f = k;
      end
    end
    m = best[31:0];
  endfunction

  function automatic void push_exp(input int id, input int c);
    int f;
    logic [31:0] m;
    ref_peak(id, 1'b0, f, m);
    exp0.push_back('{c, f, m});
    ref_peak(id, 1'b1, f, m);
    exp1.push_back('{c, f, m});
  endfunction

  // Engine finishes its current frame at edge cur_end; one frame may wait in hold.
  function automatic void build_expected(input int base, input int n);
    int cur_end = -1000;
    int hold = -1;
    exp0.delete();
    exp1.delete();
    exp_ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      int s = base + off[i] + 1;
      while (hold >= 0 && cur_end < s) begin
        cur_end += 16;
        push_exp(hold, cur_end);
        hold = -1;
      end
      if (s >= cur_end) begin
        if (hold >= 0) begin
          cur_end += 16;
          push_exp(hold, cur_end);
          hold = i;
        end else begin
          cur_end = s + 16;
          push_exp(i, cur_end);
        end
      end else if (hold < 0) begin
        hold = i;
      end else begin
        exp_ovf = 1'b1;
      end
    end
    if (hold >= 0) begin
      cur_end += 16;
      push_exp(hold, cur_end);
    end
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    fft_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_schedule(input string name, input int n, input bit check_busy);
    int base, last;
    cap0.delete();
    cap1.delete();
    @(negedge clk);
    base = cyc;
    build_expected(base, n);
    last = exp0[exp0.size() - 1].c;
    busy_gaps = 0;
    win_lo = base + off[0] + 1;
    win_hi = last;
    for (int k = 0; k <= off[n-1]; k++) begin
      int hit = -1;
      for (int j = 0; j < n; j++) if (off[j] == k) hit = j;
      if (hit >= 0) begin
        fft_valid = 1'b1;
        for (int b = 0; b < 16; b++) din[b] = frm[hit][b];
      end else begin
        fft_valid = 1'b0;
        for (int b = 0; b < 16; b++) din[b] = $urandom;
      end
      @(negedge clk);
    end
    fft_valid = 1'b0;
    for (int t = 0; t < 3000 && cyc < last + 3; t++) @(negedge clk);
    win_hi = 0;

    vectors++;
    if (cap0.size() !== exp0.size()) begin
      miscompares++;
      $display("FAIL %s done_count0 got %0d exp %0d", name, cap0.size(), exp0.size());
    end
    vectors++;
    if (cap1.size() !== exp1.size()) begin
      miscompares++;
      $display("FAIL %s done_count1 got %0d exp %0d", name, cap1.size(), exp1.size());
    end
    for (int i = 0; i < exp0.size() && i < cap0.size(); i++) begin
      $display("%s: frame %0d done@%0d freq %0d mag %08h", name, i, cap0[i].c - base, cap0[i].f, cap0[i].m);
      vectors++;
      if (cap0[i].c !== exp0[i].c || cap0[i].f !== exp0[i].f || cap0[i].m !== exp0[i].m) begin
        miscompares++;
        $display("FAIL %s dc0_ev%0d got c=%0d f=%0d m=%08h exp c=%0d f=%0d m=%08h", name, i,
                 cap0[i].c - base, cap0[i].f, cap0[i].m, exp0[i].c - base, exp0[i].f, exp0[i].m);
      end
    end
    for (int i = 0; i < exp1.size() && i < cap1.size(); i++) begin
      vectors++;
      if (cap1[i].c !== exp1[i].c || cap1[i].f !== exp1[i].f || cap1[i].m !== exp1[i].m) begin
        miscompares++;
        $display("FAIL %s skipdc_ev%0d got c=%0d f=%0d m=%08h exp c=%0d f=%0d m=%08h", name, i,
                 cap1[i].c - base, cap1[i].f, cap1[i].m, exp1[i].c - base, exp1[i].f, exp1[i].m);
      end
    end
    vectors++;
    if (ovf0 !== exp_ovf || ovf1 !== exp_ovf) begin
      miscompares++;
      $display("FAIL %s ovf got %b/%b exp %b", name, ovf0, ovf1, exp_ovf);
    end
    if (check_busy) begin
      vectors++;
      if (busy_gaps !== 0) begin
        miscompares++;
        $display("FAIL %s busy_gaps got %0d exp 0", name, busy_gaps);
      end
    end
  endtask

  function automatic logic [31:0] small_bin();
    logic [15:0] re = 16'($urandom_range(0, 511)) - 16'd256;
    logic [15:0] im = 16'($urandom_range(0, 511)) - 16'd256;
    return {re, im};
  endfunction

  task automatic check_idle_outputs(input string name);
    vectors++;
    if ({done0, freq0, peak0, busy0, ovf0} !== 39'd0 || {done1, freq1, peak1, busy1, ovf1} !== 39'd0) begin
      miscompares++;
      $display("FAIL %s outputs got %b %h %h %b %b / %b %h %h %b %b exp all zero", name,
               done0, freq0, peak0, busy0, ovf0, done1, freq1, peak1, busy1, ovf1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    fft_valid = 1'b0;
    for (int b = 0; b < 16; b++) din[b] = 32'd0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset_asserted");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset_released");
  endtask

  task automatic test_tie();
    do_reset();
    for (int b = 0; b < 16; b++) frm[0][b] = 32'd0;
    frm[0][1]  = 32'h0300_0000;
    frm[0][15] = 32'h0300_0000;
    off[0] = 0;
    run_schedule("tie", 1, 1'b1);
  endtask

  task automatic test_max_mag();
    do_reset();
    for (int b = 0; b < 16; b++) frm[0][b] = 32'h0100_0100;
    frm[0][7] = 32'h8000_8000;
    off[0] = 0;
    run_schedule("max_mag", 1, 1'b1);
  endtask

  task automatic test_back_to_back();
    int pk [3] = '{3, 9, 12};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      for (int b = 0; b < 16; b++) frm[i][b] = small_bin();
      frm[i][pk[i]] = {16'h4000, 16'(16'h1000 + $urandom_range(0, 255))};
      off[i] = 16 * i;
    end
    run_schedule("back_to_back", 3, 1'b1);
  endtask

  task automatic test_pend_drop();
    do_reset();
    for (int i = 0; i < 3; i++) for (int b = 0; b < 16; b++) frm[i][b] = $urandom;
    off[0] = 0;
    off[1] = 2;
    off[2] = 5;
    run_schedule("pend_drop", 3, 1'b1);
  endtask

  task automatic test_skip_dc();
    do_reset();
    for (int b = 0; b < 16; b++) frm[0][b] = 32'd0;
    frm[0][0] = 32'h7FFF_0000;
    frm[0][4] = 32'h0010_0000;
    off[0] = 0;
    run_schedule("skip_dc", 1, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int o = 0;
      do_reset();
      for (int i = 0; i < 20; i++) begin
        for (int b = 0; b < 16; b++) frm[i][b] = ($urandom_range(0, 1) != 0) ? $urandom : small_bin();
        if ($urandom_range(0, 3) == 0) frm[i][$urandom_range(8, 15)] = frm[i][$urandom_range(0, 7)];
        off[i] = o;
        o += (r == 0) ? 16 : $urandom_range(1, 24);
      end
      run_schedule("random", 20, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int b = 0; b < 16; b++) frm[0][b] = $urandom;
    off[0] = 0;
    run_schedule("pre_mid_reset", 1, 1'b0);
    cap0.delete();
    cap1.delete();
    @(negedge clk);
    fft_valid = 1'b1;
    for (int b = 0; b < 16; b++) din[b] = $urandom;
    @(negedge clk);
    fft_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (24) @(negedge clk);
    vectors++;
    if (cap0.size() + cap1.size() !== 0) begin
      miscompares++;
      $display("FAIL mid_reset_done got %0d pulses exp 0", cap0.size() + cap1.size());
    end
    check_idle_outputs("post_mid_reset");
    for (int b = 0; b < 16; b++) frm[0][b] = small_bin();
    run_schedule("after_mid_reset", 1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_tie();
    test_max_mag();
    test_back_to_back();
    test_pend_drop();
    test_skip_dc();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
